// File: rtl/cam_stat_ctrl.sv
// Frame-decimating camera statistics controller: steers accumulator, divider and average publish.
// Optional divider watchdog enabled by defining CAM_STAT_TIMEOUT_EN.
module cam_stat_ctrl #(
    parameter int unsigned FRAME_DIV   = 30,
    parameter int unsigned DIV_TIMEOUT = 64
) (
    input  logic       VGA_CLK,
    input  logic       RST,
    input  logic       V_SYNC,
    input  logic       pixel_valid,
    input  logic       div_done,
    input  logic       div_zero,
    input  logic [7:0] div_quot,
    output logic       acc_clr,
    output logic       acc_en,
    output logic       div_start,
    output logic [7:0] color,
    output logic       color_valid,
    output logic       overrun,
    output logic       div_err,
    output logic [7:0] frame_cnt
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned TMO_W = 16;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ACCUM    = 2'd1;
    localparam logic [1:0] ST_DIV_WAIT = 2'd2;

    localparam logic [CNT_W-1:0] LAST_FRAME = CNT_W'(FRAME_DIV - 1);

    logic [1:0]       state_q, state_d;
    logic             vs_q;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [7:0]       color_q, color_d;
    logic             color_valid_q, color_valid_d;
    logic             div_start_q, div_start_d;
    logic             acc_clr_q, acc_clr_d;
    logic             overrun_q, overrun_d;
    logic             div_err_q, div_err_d;

    logic             fb;
    logic             last_frame;
    logic [CNT_W-1:0] frame_cnt_inc;
    logic             tmo_expire;

    // Frame boundary is the sampled falling edge of the active-low vertical sync.
    assign fb            = vs_q & ~V_SYNC;
    assign last_frame    = (frame_cnt_q == LAST_FRAME);
    assign frame_cnt_inc = frame_cnt_q + CNT_W'(1);

`ifdef CAM_STAT_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

    assign tmo_expire = (state_q == ST_DIV_WAIT) &&
                        (tmo_cnt_q == TMO_W'(DIV_TIMEOUT - 1));

    // Counts cycles spent waiting; restarts whenever a new divide is launched.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (state_q != ST_DIV_WAIT) begin
            tmo_cnt_d = '0;
        end else if (!tmo_expire) begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
        if (div_start_d) begin
            tmo_cnt_d = '0;
        end
    end

    always_ff @(posedge VGA_CLK or posedge RST) begin
        if (RST) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    logic [TMO_W-1:0] unused_div_timeout;

    assign tmo_expire         = 1'b0;
    assign unused_div_timeout = TMO_W'(DIV_TIMEOUT);
`endif

    // Next-state and registered-output decode.
    always_comb begin
        state_d       = state_q;
        frame_cnt_d   = frame_cnt_q;
        color_d       = color_q;
        color_valid_d = 1'b0;
        div_start_d   = 1'b0;
        acc_clr_d     = 1'b0;
        overrun_d     = overrun_q;
        div_err_d     = div_err_q;

        case (state_q)
            ST_IDLE: begin
                if (fb) begin
                    acc_clr_d   = 1'b1;
                    frame_cnt_d = '0;
                    state_d     = ST_ACCUM;
                end
            end

            ST_ACCUM: begin
                if (fb) begin
                    acc_clr_d = 1'b1;
                    if (last_frame) begin
                        div_start_d = 1'b1;
                        frame_cnt_d = '0;
                        state_d     = ST_DIV_WAIT;
                    end else begin
                        frame_cnt_d = frame_cnt_inc;
                    end
                end
            end

            ST_DIV_WAIT: begin
                if (div_done) begin
                    state_d = ST_ACCUM;
                    if (div_zero) begin
                        div_err_d = 1'b1;
                    end else begin
                        color_d       = div_quot;
                        color_valid_d = 1'b1;
                    end
                end else if (tmo_expire) begin
                    div_err_d = 1'b1;
                    state_d   = ST_ACCUM;
                end

                // A boundary while busy relaunches only if the divider answers this cycle.
                if (fb) begin
                    acc_clr_d = 1'b1;
                    if (last_frame) begin
                        frame_cnt_d = '0;
                        if (div_done) begin
                            div_start_d = 1'b1;
                            state_d     = ST_DIV_WAIT;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end else begin
                        frame_cnt_d = frame_cnt_inc;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge VGA_CLK or posedge RST) begin
        if (RST) begin
            state_q       <= ST_IDLE;
            vs_q          <= 1'b1;
            frame_cnt_q   <= '0;
            color_q       <= '0;
            color_valid_q <= 1'b0;
            div_start_q   <= 1'b0;
            acc_clr_q     <= 1'b0;
            overrun_q     <= 1'b0;
            div_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            vs_q          <= V_SYNC;
            frame_cnt_q   <= frame_cnt_d;
            color_q       <= color_d;
            color_valid_q <= color_valid_d;
            div_start_q   <= div_start_d;
            acc_clr_q     <= acc_clr_d;
            overrun_q     <= overrun_d;
            div_err_q     <= div_err_d;
        end
    end

    // Accumulate only during active video once a frame boundary has been seen.
    assign acc_en      = pixel_valid & V_SYNC & (state_q != ST_IDLE);

    assign acc_clr     = acc_clr_q;
    assign div_start   = div_start_q;
    assign color       = color_q;
    assign color_valid = color_valid_q;
    assign overrun     = overrun_q;
    assign div_err     = div_err_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_cam_stat_ctrl.sv
// Scoreboard bench for cam_stat_ctrl (FRAME_DIV=3, DIV_TIMEOUT=16).
module tb_cam_stat_ctrl;

    localparam int unsigned FRAME_DIV   = 3;
    localparam int unsigned DIV_TIMEOUT = 16;

    logic       VGA_CLK = 1'b0;
    logic       RST;
    logic       V_SYNC;
    logic       pixel_valid;
    logic       div_done;
    logic       div_zero;
    logic [7:0] div_quot;
    logic       acc_clr;
    logic       acc_en;
    logic       div_start;
    logic [7:0] color;
    logic       color_valid;
    logic       overrun;
    logic       div_err;
    logic [7:0] frame_cnt;

    int total = 0;
    int bad   = 0;
    int n_clr = 0;
    int n_start = 0;
    int n_cv  = 0;
    int c0;
    logic [7:0] exp_q[$];

    cam_stat_ctrl #(
        .FRAME_DIV  (FRAME_DIV),
        .DIV_TIMEOUT(DIV_TIMEOUT)
    ) u_dut (
        .VGA_CLK    (VGA_CLK),
        .RST        (RST),
        .V_SYNC     (V_SYNC),
        .pixel_valid(pixel_valid),
        .div_done   (div_done),
        .div_zero   (div_zero),
        .div_quot   (div_quot),
        .acc_clr    (acc_clr),
        .acc_en     (acc_en),
        .div_start  (div_start),
        .color      (color),
        .color_valid(color_valid),
        .overrun    (overrun),
        .div_err    (div_err),
        .frame_cnt  (frame_cnt)
    );

    always #5 VGA_CLK = ~VGA_CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge VGA_CLK);
        #1;
    endtask

    task automatic vs_edge();
        V_SYNC = 1'b0;
        tick(1);
        V_SYNC = 1'b1;
        tick(2);
    endtask

    task automatic pulse_done(input logic zero, input logic [7:0] quot, input logic push);
        div_done = 1'b1;
        div_zero = zero;
        div_quot = quot;
        if (push) exp_q.push_back(quot);
        tick(1);
        div_done = 1'b0;
        div_zero = 1'b0;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick(2);
        RST = 1'b0;
        tick(1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_fc"}, frame_cnt, 0);
        chk({tag, "_color"}, color, 0);
        chk({tag, "_cv"}, color_valid, 0);
        chk({tag, "_start"}, div_start, 0);
        chk({tag, "_clr"}, acc_clr, 0);
        chk({tag, "_ovr"}, overrun, 0);
        chk({tag, "_err"}, div_err, 0);
    endtask

    // Pulse monitor: counts pulses, checks width, pops the scoreboard on publish.
    initial begin
        logic clr_p, start_p, cv_p;
        clr_p = 1'b0; start_p = 1'b0; cv_p = 1'b0;
        forever begin
            @(negedge VGA_CLK);
            if (RST) begin
                clr_p = 1'b0; start_p = 1'b0; cv_p = 1'b0;
            end else begin
                if (acc_clr) begin
                    n_clr++;
                    chk("clr_1cyc", clr_p, 0);
                    chk("fc_max", frame_cnt <= 8'(FRAME_DIV - 1), 1);
                end
                if (div_start) begin
                    n_start++;
                    chk("start_1cyc", start_p, 0);
                end
                if (color_valid) begin
                    n_cv++;
                    chk("cv_1cyc", cv_p, 0);
                    if (exp_q.size() == 0) chk("cv_unexpected", 1, 0);
                    else chk("color_sb", color, exp_q.pop_front());
                end
                clr_p = acc_clr; start_p = div_start; cv_p = color_valid;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; V_SYNC = 1'b1; pixel_valid = 1'b0;
        div_done = 1'b0; div_zero = 1'b0; div_quot = 8'd0;
        tick(2);
        chk_reset_vals("rst");
        pixel_valid = 1'b1;
        RST = 1'b0;
        tick(2);
        chk("idle_acc_en", acc_en, 0);
        pixel_valid = 1'b0;

        // Four boundaries; the divide launches on the fourth only.
        vs_edge(); chk("e1_fc", frame_cnt, 0);
        vs_edge(); chk("e2_fc", frame_cnt, 1);
        vs_edge(); chk("e3_fc", frame_cnt, 2);
        chk("e3_start", n_start, 0);
        chk("e3_clr", n_clr, 3);
        V_SYNC = 1'b0;
        tick(1);
        chk("e4_start", div_start, 1);
        V_SYNC = 1'b1;
        tick(2);
        tick(3);
        pulse_done(1'b0, 8'd150, 1'b1);
        tick(2);
        chk("avg_color", color, 150);
        chk("avg_cv_cnt", n_cv, 1);
        chk("avg_fc", frame_cnt, 0);

        // Long vsync low: single clear, no accumulation.
        c0 = n_clr;
        V_SYNC = 1'b0; pixel_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("vs_low_acc_en", acc_en, 0);
        end
        V_SYNC = 1'b1;
        tick(2);
        chk("vs_low_clr", n_clr - c0, 1);
        chk("acc_en_on", acc_en, 1);
        pixel_valid = 1'b0;

        // Divide-by-zero keeps the old color.
        vs_edge();
        vs_edge();
        chk("dz_start", n_start, 2);
        tick(3);
        pulse_done(1'b1, 8'd9, 1'b0);
        tick(2);
        chk("dz_color", color, 150);
        chk("dz_err", div_err, 1);
        chk("dz_cv", n_cv, 1);

        // div_done outside DIV_WAIT is ignored.
        pulse_done(1'b0, 8'd77, 1'b0);
        tick(2);
        chk("stray_color", color, 150);
        chk("stray_cv", n_cv, 1);

        // Divider stalls: the next decimation slot is suppressed.
        vs_edge(); vs_edge(); vs_edge();
        chk("ov_start", n_start, 3);
        vs_edge(); vs_edge();
        chk("ov_pre", overrun, 0);
        chk("ov_pre_fc", frame_cnt, 2);
        c0 = n_clr;
        vs_edge();
        chk("ov_set", overrun, 1);
        chk("ov_no_start", n_start, 3);
        chk("ov_clr", n_clr - c0, 1);
        chk("ov_fc", frame_cnt, 0);

        // Boundary and divider answer coincide on the last frame: relaunch.
        vs_edge(); vs_edge();
        V_SYNC = 1'b0;
        pulse_done(1'b0, 8'd200, 1'b1);
        V_SYNC = 1'b1;
        chk("co_start", div_start, 1);
        chk("co_color", color, 200);
        tick(2);
        chk("co_start_cnt", n_start, 4);
        tick(3);
        pulse_done(1'b0, 8'd99, 1'b1);
        tick(2);
        chk("co_color2", color, 99);
        chk("co_cv_cnt", n_cv, 3);
        chk("ov_sticky", overrun, 1);

        // Divider never answers after a fresh start.
        do_reset();
        c0 = n_start;
        vs_edge(); vs_edge(); vs_edge(); vs_edge();
        chk("tmo_start", n_start - c0, 1);
        c0 = n_cv;
`ifdef CAM_STAT_TIMEOUT_EN
        tick(13);
        chk("tmo_pre_err", div_err, 0);
        tick(1);
        chk("tmo_err", div_err, 1);
        pulse_done(1'b0, 8'd55, 1'b0);
        tick(2);
        chk("tmo_late_cv", n_cv - c0, 0);
        chk("tmo_color", color, 0);
`else
        tick(40);
        pulse_done(1'b0, 8'd55, 1'b1);
        tick(2);
        chk("wait_color", color, 55);
        chk("wait_cv", n_cv - c0, 1);
        chk("wait_err", div_err, 0);
`endif

        // Reset mid-divide abandons it.
        do_reset();
        c0 = n_start;
        vs_edge(); vs_edge(); vs_edge(); vs_edge();
        chk("rd_start", n_start - c0, 1);
        RST = 1'b1;
        tick(1);
        chk_reset_vals("rd");
        RST = 1'b0;
        tick(1);
        c0 = n_cv;
        pulse_done(1'b0, 8'd123, 1'b0);
        tick(2);
        chk("rd_color", color, 0);
        chk("rd_cv", n_cv - c0, 0);
        pixel_valid = 1'b1;
        chk("rd_idle_acc_en", acc_en, 0);
        pixel_valid = 1'b0;
        c0 = n_start;
        vs_edge();
        chk("rd_idle_fc", frame_cnt, 0);
        chk("rd_idle_start", n_start - c0, 0);

        chk("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
